row_len_gen: RTL and testbench

ROW_LEN_GEN -- requirements
Module: row_len_gen

---
 rtl/spmv_pkg.sv | 13 +
 rtl/axis_skid_buf.sv | 67 ++++++
 rtl/row_len_gen.sv | 101 ++++++++++
 tb/tb_row_len_gen.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spmv_pkg.sv
// spmv_pkg: definitions shared by the SpMV pipeline stages.
//   PTR_W_DEF   - default width of CSR row pointers and row lengths
//   row_state_t - row_len_gen state encoding
package spmv_pkg;

  localparam int unsigned PTR_W_DEF = 32;

  typedef enum logic {
    ST_BASE = 1'b0,  // next beat is the first pointer of a matrix
    ST_RUN  = 1'b1   // next beats produce row lengths
  } row_state_t;

endpackage

// File: rtl/axis_skid_buf.sv
// axis_skid_buf: 2-entry AXI-Stream skid buffer.
// Outputs come straight from registers. The upstream ready is derived
// only from the registered fill level, so no combinational path runs
// from i_out_ready to o_in_ready.
//   clk, rst     - clock, synchronous active-high reset
//   i_in_valid   - push request
//   i_in_data    - push data (W bits)
//   o_in_ready   - buffer can take a beat this cycle
//   o_out_valid  - head entry valid
//   o_out_data   - head entry data (W bits)
//   i_out_ready  - downstream accepts the head entry
module axis_skid_buf #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_in_valid,
  input  logic [W-1:0] i_in_data,
  output logic         o_in_ready,
  output logic         o_out_valid,
  output logic [W-1:0] o_out_data,
  input  logic         i_out_ready
);

  logic [W-1:0] r_head;
  logic [W-1:0] r_skid;
  logic [1:0]   r_cnt;
  logic         w_pop;
  logic         w_push;

  assign o_in_ready  = !rst && (r_cnt != 2'd2);
  assign o_out_valid = (r_cnt != 2'd0);
  assign o_out_data  = r_head;
  assign w_pop       = o_out_valid && i_out_ready;
  // A caller may push into a full buffer in the same cycle as a pop.
  assign w_push      = i_in_valid && !rst && ((r_cnt != 2'd2) || w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head <= '0;
      r_skid <= '0;
      r_cnt  <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_cnt == 2'd0) r_head <= i_in_data;
          else               r_skid <= i_in_data;
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_head <= r_skid;
          r_cnt  <= r_cnt - 2'd1;
        end
        2'b11: begin
          if (r_cnt == 2'd1) begin
            r_head <= i_in_data;
          end else begin
            r_head <= r_skid;
            r_skid <= i_in_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/row_len_gen.sv
// row_len_gen: converts a CSR row-pointer stream into a row-length stream.
// The first pointer of each matrix is a base; every following pointer
// yields (ptr - previous ptr). A decreasing pointer sets sticky ptr_err
// and yields length 0.
//   clk, rst        - clock, synchronous active-high reset
//   s_ptr_valid/data/last/ready - row-pointer AXIS input
//   times_valid/data/ready      - row-length AXIS output (registered)
//   rows_out        - rows emitted in the current matrix
//   mat_done        - pulse when the final beat of a matrix is accepted
//   ptr_err         - sticky decreasing-pointer flag
module row_len_gen
  import spmv_pkg::*;
#(
  parameter bit          SKIP_EMPTY = 1'b0,
  parameter int unsigned PTR_W      = PTR_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_ptr_valid,
  input  logic [PTR_W-1:0] s_ptr_data,
  input  logic             s_ptr_last,
  output logic             s_ptr_ready,
  output logic             times_valid,
  output logic [PTR_W-1:0] times_data,
  input  logic             times_ready,
  output logic [PTR_W-1:0] rows_out,
  output logic             mat_done,
  output logic             ptr_err
);

  row_state_t       r_state;
  row_state_t       w_state_nxt;
  logic [PTR_W-1:0] r_prev;
  logic [PTR_W-1:0] r_rows;
  logic             r_err;
  logic             w_acc;
  logic             w_dec;
  logic [PTR_W-1:0] w_len;
  logic             w_push;
  logic             w_base;
  logic             w_done;

  assign w_acc = s_ptr_valid && s_ptr_ready;
  assign w_dec = (s_ptr_data < r_prev);
  assign w_len = w_dec ? '0 : (s_ptr_data - r_prev);

  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_base      = 1'b0;
    w_done      = 1'b0;
    if (w_acc) begin
      case (r_state)
        ST_BASE: begin
          w_base = 1'b1;
          if (s_ptr_last) w_done = 1'b1;
          else            w_state_nxt = ST_RUN;
        end
        ST_RUN: begin
          w_push = !(SKIP_EMPTY && (w_len == '0));
          if (s_ptr_last) begin
            w_done      = 1'b1;
            w_state_nxt = ST_BASE;
          end
        end
        default: w_state_nxt = ST_BASE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_BASE;
      r_prev  <= '0;
      r_rows  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_acc) r_prev <= s_ptr_data;
      if (w_base)      r_rows <= '0;
      else if (w_push) r_rows <= r_rows + PTR_W'(1);
      if (w_acc && (r_state == ST_RUN) && w_dec) r_err <= 1'b1;
    end
  end

  axis_skid_buf #(.W(PTR_W)) u_buf (
    .clk         (clk),
    .rst         (rst),
    .i_in_valid  (w_push),
    .i_in_data   (w_len),
    .o_in_ready  (s_ptr_ready),
    .o_out_valid (times_valid),
    .o_out_data  (times_data),
    .i_out_ready (times_ready)
  );

  assign rows_out = r_rows;
  assign mat_done = w_done;
  assign ptr_err  = r_err;

endmodule

// File: tb/tb_row_len_gen.sv
module tb_row_len_gen;

  localparam int PW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [1:0]    sv, sl, sr, tv, tr, md, pe;
  logic [PW-1:0] sd [2];
  logic [PW-1:0] td [2];
  logic [PW-1:0] ro [2];

  row_len_gen #(.SKIP_EMPTY(1'b0), .PTR_W(PW)) dut0 (
    .clk(clk), .rst(rst),
    .s_ptr_valid(sv[0]), .s_ptr_data(sd[0]), .s_ptr_last(sl[0]), .s_ptr_ready(sr[0]),
    .times_valid(tv[0]), .times_data(td[0]), .times_ready(tr[0]),
    .rows_out(ro[0]), .mat_done(md[0]), .ptr_err(pe[0])
  );

  row_len_gen #(.SKIP_EMPTY(1'b1), .PTR_W(PW)) dut1 (
    .clk(clk), .rst(rst),
    .s_ptr_valid(sv[1]), .s_ptr_data(sd[1]), .s_ptr_last(sl[1]), .s_ptr_ready(sr[1]),
    .times_valid(tv[1]), .times_data(td[1]), .times_ready(tr[1]),
    .rows_out(ro[1]), .mat_done(md[1]), .ptr_err(pe[1])
  );

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  // stimulus
  int unsigned g_ptr[$];
  bit          g_last[$];
  // observations
  int unsigned q_out[$];
  int unsigned q_out_cyc[$];
  int unsigned q_done_ptr[$];
  int          g_stall_viol;
  int          g_first_block;
  bit          g_timeout;
  // reference results
  int unsigned m_out[$];
  int unsigned m_rows;
  bit          m_err;
  int unsigned m_done;

  // Reference: split the stream into matrices at each last flag, then take
  // adjacent differences inside each matrix.
  task automatic model(input bit skip);
    int unsigned cur[$];
    int unsigned len;
    int unsigned rows;
    m_out.delete(); m_rows = 0; m_err = 0; m_done = 0;
    for (int i = 0; i < g_ptr.size(); i++) begin
      cur.push_back(g_ptr[i]);
      if (g_last[i] || i == g_ptr.size() - 1) begin
        rows = 0;
        for (int k = 1; k < cur.size(); k++) begin
          if (cur[k] < cur[k-1]) begin
            m_err = 1; len = 0;
          end else begin
            len = cur[k] - cur[k-1];
          end
          if (!(skip && len == 0)) begin
            m_out.push_back(len);
            rows++;
          end
        end
        m_rows = rows;
        if (g_last[i]) m_done++;
        cur.delete();
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sv = '0; sl = '0; tr = '1;
    sd[0] = '0; sd[1] = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // mode 0: ready high, 1: ready low for low_cyc cycles, 2: random ready
  task automatic run_stream(input int sel, input int mode, input int low_cyc);
    int idx = 0;
    int cyc = 0;
    int acc_cnt = 0;
    bit acc;
    bit prev_stall = 0;
    logic [PW-1:0] prev_data = '0;
    q_out.delete(); q_out_cyc.delete(); q_done_ptr.delete();
    g_stall_viol = 0; g_first_block = -1; g_timeout = 0;
    forever begin
      @(negedge clk);
      if (idx < g_ptr.size()) begin
        sv[sel] = 1'b1; sd[sel] = g_ptr[idx]; sl[sel] = g_last[idx];
      end else begin
        sv[sel] = 1'b0; sl[sel] = 1'b0;
      end
      case (mode)
        0:       tr[sel] = 1'b1;
        1:       tr[sel] = (cyc >= low_cyc);
        default: tr[sel] = ($urandom_range(0, 3) != 0);
      endcase
      #1;
      if (prev_stall && (!tv[sel] || td[sel] !== prev_data)) g_stall_viol++;
      if (idx >= g_ptr.size() && !tv[sel]) break;
      if (sv[sel] && !sr[sel] && g_first_block < 0) g_first_block = acc_cnt;
      if (tv[sel] && tr[sel]) begin
        q_out.push_back(td[sel]);
        q_out_cyc.push_back(cyc);
      end
      if (md[sel]) q_done_ptr.push_back(sd[sel]);
      acc = sv[sel] && sr[sel];
      prev_stall = tv[sel] && !tr[sel];
      prev_data = td[sel];
      @(posedge clk);
      if (acc) begin idx++; acc_cnt++; end
      cyc++;
      if (cyc > 3000) begin g_timeout = 1; break; end
    end
    sv[sel] = 1'b0; sl[sel] = 1'b0; tr[sel] = 1'b1;
    n_total++;
    if (g_timeout) $display("FAIL timeout dut%0d: stream did not drain within cycle budget", sel);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sv = '0; sl = '0; tr = '1;
    sd[0] = '0; sd[1] = '0;
    repeat (2) @(negedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      n_total += 6;
      if (tv[s] !== 1'b0) $display("FAIL reset_times_valid dut%0d: got %b want 0", s, tv[s]); else n_pass++;
      if (td[s] !== '0) $display("FAIL reset_times_data dut%0d: got %0d want 0", s, td[s]); else n_pass++;
      if (ro[s] !== '0) $display("FAIL reset_rows_out dut%0d: got %0d want 0", s, ro[s]); else n_pass++;
      if (md[s] !== 1'b0) $display("FAIL reset_mat_done dut%0d: got %b want 0", s, md[s]); else n_pass++;
      if (pe[s] !== 1'b0) $display("FAIL reset_ptr_err dut%0d: got %b want 0", s, pe[s]); else n_pass++;
      if (sr[s] !== 1'b0) $display("FAIL reset_s_ptr_ready dut%0d: got %b want 0", s, sr[s]); else n_pass++;
    end
    rst = 1'b0;
  endtask

  // Compares collected outputs and flags with the reference model.
  task automatic test_compare(input int sel, input string tag);
    n_total++;
    if (q_out.size() != m_out.size())
      $display("FAIL %s_count dut%0d: got %0d lengths want %0d", tag, sel, q_out.size(), m_out.size());
    else n_pass++;
    for (int i = 0; i < q_out.size() && i < m_out.size(); i++) begin
      n_total++;
      if (q_out[i] != m_out[i])
        $display("FAIL %s_data[%0d] dut%0d: got %0d want %0d", tag, i, sel, q_out[i], m_out[i]);
      else n_pass++;
    end
    n_total += 4;
    if (q_done_ptr.size() != m_done)
      $display("FAIL %s_mat_done dut%0d: got %0d pulses want %0d", tag, sel, q_done_ptr.size(), m_done);
    else n_pass++;
    if (ro[sel] !== m_rows)
      $display("FAIL %s_rows_out dut%0d: got %0d want %0d", tag, sel, ro[sel], m_rows);
    else n_pass++;
    if (pe[sel] !== m_err)
      $display("FAIL %s_ptr_err dut%0d: got %b want %b", tag, sel, pe[sel], m_err);
    else n_pass++;
    if (g_stall_viol != 0)
      $display("FAIL %s_stable dut%0d: got %0d unstable stalls want 0", tag, sel, g_stall_viol);
    else n_pass++;
  endtask

  task automatic test_basic(input int sel);
    do_reset();
    g_ptr = '{0, 3, 3, 7, 8};
    g_last = '{0, 0, 0, 0, 1};
    model(sel[0]);
    run_stream(sel, 0, 0);
    test_compare(sel, "basic");
    n_total++;
    if (q_done_ptr.size() != 1 || q_done_ptr[0] != 8)
      $display("FAIL basic_done_beat dut%0d: got %0d pulses want one at beat 8", sel, q_done_ptr.size());
    else n_pass++;
    if (sel == 0) begin
      for (int i = 1; i < q_out_cyc.size(); i++) begin
        n_total++;
        if (q_out_cyc[i] != q_out_cyc[0] + i)
          $display("FAIL basic_consecutive[%0d]: got cycle %0d want %0d", i, q_out_cyc[i], q_out_cyc[0] + i);
        else n_pass++;
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    g_ptr = '{0, 5, 10, 15, 20};
    g_last = '{0, 0, 0, 0, 1};
    model(1'b0);
    run_stream(0, 1, 4);
    test_compare(0, "bp");
    n_total++;
    if (g_first_block != 3)
      $display("FAIL bp_ready_drop: got %0d beats accepted before stall want 3", g_first_block);
    else n_pass++;
  endtask

  task automatic test_ptr_err();
    do_reset();
    g_ptr = '{10, 6, 9};
    g_last = '{0, 0, 1};
    model(1'b0);
    run_stream(0, 0, 0);
    test_compare(0, "err");
  endtask

  task automatic test_empty_matrix();
    do_reset();
    g_ptr = '{42, 1, 4};
    g_last = '{1, 0, 1};
    model(1'b0);
    run_stream(0, 0, 0);
    test_compare(0, "empty");
    n_total++;
    if (q_done_ptr.size() < 1 || q_done_ptr[0] != 42)
      $display("FAIL empty_done_beat: got %0d pulses want first at beat 42", q_done_ptr.size());
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    do_reset();
    tr[0] = 1'b0;
    @(negedge clk); sv[0] = 1'b1; sd[0] = 0; sl[0] = 1'b0;
    @(negedge clk); sd[0] = 4;
    @(negedge clk); sv[0] = 1'b0;
    #1;
    n_total++;
    if (tv[0] !== 1'b1) $display("FAIL midrst_buffered: got times_valid %b want 1", tv[0]); else n_pass++;
    rst = 1'b1;
    @(negedge clk); #1;
    n_total += 2;
    if (tv[0] !== 1'b0) $display("FAIL midrst_valid: got %b want 0", tv[0]); else n_pass++;
    if (sr[0] !== 1'b0) $display("FAIL midrst_ready: got %b want 0", sr[0]); else n_pass++;
    rst = 1'b0;
    g_ptr = '{100, 102};
    g_last = '{0, 1};
    model(1'b0);
    run_stream(0, 0, 0);
    test_compare(0, "midrst");
  endtask

  task automatic test_random(input int sel);
    int unsigned p;
    int nm, n;
    do_reset();
    g_ptr.delete(); g_last.delete();
    nm = $urandom_range(3, 6);
    p = $urandom_range(0, 1000);
    for (int m = 0; m < nm; m++) begin
      n = $urandom_range(1, 8);
      for (int k = 0; k < n; k++) begin
        if (k == 0) p = p + $urandom_range(0, 20);
        else if ($urandom_range(0, 9) == 0 && p > 5) p = p - $urandom_range(1, 5);
        else p = p + $urandom_range(0, 4);
        g_ptr.push_back(p);
        g_last.push_back(k == n - 1);
      end
    end
    model(sel[0]);
    run_stream(sel, 2, 0);
    test_compare(sel, "rand");
  endtask

  initial begin
    test_reset();
    test_basic(0);
    test_basic(1);
    test_backpressure();
    test_ptr_err();
    test_empty_matrix();
    test_mid_reset();
    for (int r = 0; r < 6; r++) begin
      test_random(0);
      test_random(1);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
